fma_spec_merge: RTL
===================

// Module: fma_spec_merge
// PURPOSE
//  Consumer end of the FMA special-case path. Accepts spec_mask/res_spec/class per op at
//  the spec-handler stage, carries them alongside the normal mantissa datapath for LAT
//  stages, then selects special vs normal result, builds IEEE flags and keeps a sticky
//  exception register. Drives the shared pipeline enable for the FMA datapath stages.
// PARAMETERS
//  LAT    3  stages between acceptance and dp_res valid at the last stage (legal: 1..8)
//  TAG_W  4  width of the op tag carried with each result
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous active-high reset
//  flush        in   1      sync kill of all in-flight ops; sticky_flags kept
//  in_valid     in   1      op presented at spec-handler stage
//  in_ready     out  1      = pipe_en
//  spec_mask    in   1      special result replaces datapath result
//  spec_class   in   3      0 none,1 nan-prop,2 invalid,3 overflow,4 uflow-flush,5 zero,6 inf
//  res_spec     in   32     special result value
//  in_tag       in   TAG_W  op tag
//  pipe_en      out  1      datapath stage enable; = !out_valid | out_ready
//  dp_res       in   32     normal rounded result, aligned with side-pipe last stage
//  dp_ovf       in   1      datapath overflow
//  dp_unf       in   1      datapath underflow (tiny and inexact)
//  dp_nx        in   1      datapath inexact
//  out_valid    out  1      result valid
//  out_ready    in   1      downstream accept
//  out_res      out  32     final result
//  out_tag      out  TAG_W  tag of out_res
//  out_flags    out  5      {NV,DZ,OF,UF,NX}; DZ always 0
//  clr_sticky   in   1      clear sticky register
//  sticky_flags out  5      OR of out_flags of all handshaken results since clear
// BEHAVIOUR
//  - Reset: all side-pipe valid bits 0, out_valid 0, out_res 0, out_tag 0, out_flags 0,
//    sticky_flags 0. pipe_en=1 one cycle after reset deasserts.
//  - Side pipe: LAT stages of {v,mask,class,res_spec,tag}; all advance iff pipe_en. Stage0
//    v <= in_valid & pipe_en. Bubbles (v=0) advance too; no compaction.
//  - Output register loads from last stage when pipe_en: out_valid <= last.v.
//    Latency: accept at cycle N -> out_valid at N+LAT+1 with out_ready held high.
//  - Stall: out_valid & !out_ready -> pipe_en=0, all stages and out regs hold, dp_res held
//    by datapath. Throughput 1 op/cycle when out_ready=1.
//  - Select: mask=0 -> out_res=dp_res, flags={0,0,dp_ovf,dp_unf,dp_nx}.
//    mask=1 by class: 1 -> out_res=res_spec|32'h0040_0000 (quiet), NV=~res_spec[22];
//    2 -> res_spec, NV=1; 3 -> res_spec, OF=1,NX=1; 4 -> res_spec, UF=1,NX=1;
//    5,6 -> res_spec, flags 0. mask=1 with class 0 or 7 -> res_spec, flags 0.
//  - Output fields load only with last.v=1; bubble leaves out_res/tag/flags unchanged.
//  - Sticky: on out_valid&out_ready, sticky |= out_flags. clr_sticky clears; clr_sticky in
//    same cycle as handshake -> sticky = out_flags of that result (new flags win).
//  - flush: next cycle all stage v=0 and out_valid=0; data regs unchanged; sticky unchanged;
//    in_valid in flush cycle is dropped. flush has priority over pipe_en load.
//  - rst mid-operation: same as reset values next cycle, in-flight ops lost, sticky cleared.
// TESTING
//  1 LAT=3, ready=1, op mask=0 dp_res=32'h3F80_0000 nx=1 tag=5 at cyc 10 -> out_valid cyc 14,
//    out_res 3F80_0000, flags 5'b00001, tag 5; sticky 5'b00001.
//  2 mask=1 class=1 res_spec=32'h7F80_0001 -> out_res 7FC0_0001, flags 5'b10000; with
//    res_spec=7FC0_0000 -> flags 0.
//  3 class=3 res_spec=FF80_0000 then class=4 res_spec=0000_0000 back-to-back -> flags
//    5'b00101 then 5'b00011 on consecutive cycles; sticky 5'b00111.
//  4 4 ops streamed, out_ready low 3 cycles after first out -> in_ready=0 same cycles, no op
//    lost or duplicated, tags emerge 0,1,2,3 in order.
//  5 clr_sticky coinciding with handshake of class=2 op -> sticky 5'b10000 exactly.
//  6 flush with 3 ops in flight and out_valid=1 -> out_valid 0 next cycle, no further outputs,
//    sticky unchanged; rst pulse mid-stream -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/fma_spec_merge.sv
// fma_spec_merge: consumer end of the FMA special-case path.
// Carries the special-case decision of each op alongside the mantissa datapath
// for LAT stages, then picks the special or the normal result, forms the IEEE
// flags {NV,DZ,OF,UF,NX} and accumulates them into a sticky exception register.
// pipe_en is the shared advance enable for every FMA datapath stage.
module fma_spec_merge #(
    parameter int LAT   = 3,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             spec_mask,
    input  logic [2:0]       spec_class,
    input  logic [31:0]      res_spec,
    input  logic [TAG_W-1:0] in_tag,
    output logic             pipe_en,
    input  logic [31:0]      dp_res,
    input  logic             dp_ovf,
    input  logic             dp_unf,
    input  logic             dp_nx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       out_flags,
    input  logic             clr_sticky,
    output logic [4:0]       sticky_flags
);

    // Special-case classes produced by the spec-handler stage.
    localparam logic [2:0] CLS_NAN_PROP = 3'd1;
    localparam logic [2:0] CLS_INVALID  = 3'd2;
    localparam logic [2:0] CLS_OVERFLOW = 3'd3;
    localparam logic [2:0] CLS_UFLOW    = 3'd4;

    // Quiet bit of a binary32 NaN mantissa.
    localparam logic [31:0] QNAN_BIT = 32'h0040_0000;

    // One side-pipe slot: everything the merge needs about an op except dp data.
    typedef struct packed {
        logic             v;
        logic             mask;
        logic [2:0]       cls;
        logic [31:0]      spec;
        logic [TAG_W-1:0] tag;
    } stage_t;

    stage_t           stage_q [LAT];
    stage_t           stage_d [LAT];
    stage_t           last;

    logic             out_valid_q;
    logic [31:0]      out_res_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [4:0]       out_flags_q;
    logic [4:0]       sticky_q;
    logic [4:0]       sticky_d;

    logic [31:0]      sel_res;
    logic [4:0]       sel_flags;
    logic             handshake;

    // The whole FMA pipe moves only when the output register can take a result.
    assign pipe_en   = !out_valid_q | out_ready;
    assign in_ready  = pipe_en;
    assign handshake = out_valid_q & out_ready;
    assign last      = stage_q[LAT-1];

    // Next contents of every side-pipe slot: new op at stage 0, shift elsewhere.
    always_comb begin
        // NOTE: every always_comb output gets a full default first so no path can leave it unassigned and infer a latch.
        stage_d[0] = '{v:    in_valid & pipe_en,
                       mask: spec_mask,
                       cls:  spec_class,
                       spec: res_spec,
                       tag:  in_tag};
        for (int k = 1; k < LAT; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    // Side-pipe register: bubbles advance like ops; flush kills validity only.
    always_ff @(posedge clk) begin
        // NOTE: only the valid bits are reset; payload is qualified by v, so clearing it would add reset fan-out for no behavioural gain.
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                stage_q[k].v <= 1'b0;
            end
        end else if (flush) begin
            for (int k = 0; k < LAT; k++) begin
                stage_q[k].v <= 1'b0;
            end
        end else if (pipe_en) begin
            stage_q <= stage_d;
        end
    end

    // Choose special or datapath result for the op at the last stage and form its flags.
    always_comb begin
        sel_res   = dp_res;
        sel_flags = {2'b00, dp_ovf, dp_unf, dp_nx};
        if (last.mask) begin
            sel_res   = last.spec;
            sel_flags = 5'b00000;
            case (last.cls)
                CLS_NAN_PROP: begin
                    // A signalling NaN operand is quieted and raises invalid.
                    sel_res      = last.spec | QNAN_BIT;
                    sel_flags[4] = ~last.spec[22];
                end
                CLS_INVALID:  sel_flags = 5'b10000;
                CLS_OVERFLOW: sel_flags = 5'b00101;
                CLS_UFLOW:    sel_flags = 5'b00011;
                default:      sel_flags = 5'b00000;
            endcase
        end
    end

    // Output register: valid follows the last stage, payload loads only for real ops.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (rst) begin
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_tag_q   <= '0;
            out_flags_q <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (pipe_en) begin
            out_valid_q <= last.v;
            if (last.v) begin
                out_res_q   <= sel_res;
                out_tag_q   <= last.tag;
                out_flags_q <= sel_flags;
            end
        end
    end

    // Sticky next state: a clear coinciding with a handshake keeps that result's flags.
    always_comb begin
        sticky_d = sticky_q;
        if (clr_sticky) begin
            sticky_d = handshake ? out_flags_q : 5'b00000;
        end else if (handshake) begin
            sticky_d = sticky_q | out_flags_q;
        end
    end

    // Sticky exception register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_res      = out_res_q;
    assign out_tag      = out_tag_q;
    assign out_flags    = out_flags_q;
    assign sticky_flags = sticky_q;

endmodule
